// File: rtl/calc_sequencer.sv
// Sequencer for the cached-opcode calculator: round-robin loading of two
// opcode sources onto the calculator load port, then timed execute bursts.
module calc_sequencer #(
  parameter int DEPTH = 32,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [3:0]       req0_value,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [3:0]       req1_value,
  output logic             req1_ready,
  input  logic             run_start,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             run_abort,
  output logic             calc_mode,
  output logic [2:0]       calc_opCode,
  output logic [3:0]       calc_value,
  output logic             cache_full,
  output logic [5:0]       load_count,
  output logic             busy,
  output logic             done,
  output logic             reject
);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The calculator stores every mode-0 cycle with a legal opcode, so the idle
  // bus must carry an illegal code.
  localparam logic [2:0] IDLE_OP    = 3'b111;
  localparam logic [5:0] FULL_COUNT = 6'(DEPTH);

  state_t           state_reg, state_next;
  logic             last_grant_reg, last_grant_next;
  logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;
  logic [5:0]       count_reg, count_next;
  logic [2:0]       op_reg, op_next;
  logic [3:0]       value_reg, value_next;
  logic             done_reg, done_next;
  logic             reject_reg, reject_next;

  logic [1:0]       valid;
  logic [1:0][2:0]  req_op;
  logic [1:0][3:0]  req_value;
  logic [1:0]       ready;
  logic [1:0]       legal;
  logic             full;
  logic             accept_window;
  logic             grant_idx;
  logic [2:0]       sel_op;
  logic [3:0]       sel_value;
  logic             sel_legal;

  assign valid     = {req1_valid, req0_valid};
  assign req_op    = {req1_op, req0_op};
  assign req_value = {req1_value, req0_value};

  assign full          = (count_reg == FULL_COUNT);
  assign accept_window = (state_reg == LOAD) && !full && !run_start;

  // A requester wins alone, or on a tie when the other one was granted last.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      localparam logic OTHER = 1'(1 - gi);
      assign ready[gi] = accept_window && valid[gi] &&
                         (!valid[OTHER] || (last_grant_reg == OTHER));
      assign legal[gi] = (req_op[gi][1:0] != 2'b11);
    end
  endgenerate

  assign grant_idx = ready[1];
  assign sel_op    = req_op[grant_idx];
  assign sel_value = req_value[grant_idx];
  assign sel_legal = legal[grant_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= LOAD;
      last_grant_reg <= 1'b1;
      run_cnt_reg    <= '0;
      count_reg      <= '0;
      op_reg         <= IDLE_OP;
      value_reg      <= '0;
      done_reg       <= 1'b0;
      reject_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      run_cnt_reg    <= run_cnt_next;
      count_reg      <= count_next;
      op_reg         <= op_next;
      value_reg      <= value_next;
      done_reg       <= done_next;
      reject_reg     <= reject_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    run_cnt_next    = run_cnt_reg;
    count_next      = count_reg;
    op_next         = IDLE_OP;
    value_next      = '0;
    done_next       = 1'b0;
    reject_next     = 1'b0;
    case (state_reg)
      LOAD: begin
        if (run_start) begin
          if ((count_reg == '0) || (run_cycles == '0)) begin
            done_next = 1'b1;
          end else begin
            state_next   = RUN;
            run_cnt_next = run_cycles;
          end
        end else if (|ready) begin
          last_grant_next = grant_idx;
          if (sel_legal) begin
            op_next    = sel_op;
            value_next = sel_value;
            count_next = count_reg + 6'd1;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (run_abort || (run_cnt_reg == RUN_W'(1))) begin
          state_next   = LOAD;
          run_cnt_next = '0;
          done_next    = 1'b1;
        end else begin
          run_cnt_next = run_cnt_reg - RUN_W'(1);
        end
      end
      default: state_next = LOAD;
    endcase
  end

  assign req0_ready  = ready[0];
  assign req1_ready  = ready[1];
  assign calc_mode   = (state_reg == RUN);
  assign calc_opCode = (state_reg == RUN) ? 3'b000 : op_reg;
  assign calc_value  = (state_reg == RUN) ? 4'b0000 : value_reg;
  assign cache_full  = full;
  assign load_count  = count_reg;
  assign busy        = (state_reg == RUN);
  assign done        = done_reg;
  assign reject      = reject_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: a cycle model predicts each cycle's
// outputs, queues them, and they are compared once the DUT has clocked.
module tb_calc_sequencer;
  localparam int DEPTH = 32;
  localparam int RUN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [2:0]       req0_op, req1_op;
  logic [3:0]       req0_value, req1_value;
  logic             req0_ready, req1_ready;
  logic             run_start, run_abort;
  logic [RUN_W-1:0] run_cycles;
  logic             calc_mode;
  logic [2:0]       calc_opCode;
  logic [3:0]       calc_value;
  logic             cache_full;
  logic [5:0]       load_count;
  logic             busy, done, reject;

  calc_sequencer #(.DEPTH(DEPTH), .RUN_W(RUN_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_value(req0_value), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_value(req1_value), .req1_ready(req1_ready),
    .run_start(run_start), .run_cycles(run_cycles), .run_abort(run_abort),
    .calc_mode(calc_mode), .calc_opCode(calc_opCode), .calc_value(calc_value),
    .cache_full(cache_full), .load_count(load_count), .busy(busy),
    .done(done), .reject(reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode; int op; int val; int count; int full; int busy; int done; int rej;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_run = 0, m_cnt = 0, m_last = 1, m_count = 0;
  int mode_cycles = 0, done_cnt = 0, reject_cnt = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic drive_req(bit v0, int op0, int val0, bit v1, int op1, int val1);
    req0_valid = v0; req0_op = 3'(op0); req0_value = 4'(val0);
    req1_valid = v1; req1_op = 3'(op1); req1_value = 4'(val1);
  endtask

  task automatic clear_inputs();
    drive_req(0, 0, 0, 0, 0, 0);
    run_start = 1'b0; run_cycles = '0; run_abort = 1'b0;
  endtask

  // One clock: check ready, predict the next cycle, clock, compare.
  task automatic step();
    bit gok, r0, r1;
    int op, val;
    exp_t e, got;
    @(negedge clk);
    gok = (m_run == 0) && (m_count < DEPTH) && !run_start;
    r0 = gok && req0_valid && (!req1_valid || m_last == 1);
    r1 = gok && req1_valid && (!req0_valid || m_last == 0);
    check("req0_ready", 32'(req0_ready), 32'(r0));
    check("req1_ready", 32'(req1_ready), 32'(r1));
    e = '{mode: 0, op: 7, val: 0, count: 0, full: 0, busy: 0, done: 0, rej: 0};
    if (!reset) begin
      m_run = 0; m_cnt = 0; m_last = 1; m_count = 0;
    end else if (m_run == 0) begin
      if (run_start) begin
        if (m_count == 0 || run_cycles == 0) e.done = 1;
        else begin m_run = 1; m_cnt = int'(run_cycles); end
        $display("run_start cycles=%0d count=%0d", run_cycles, m_count);
      end else if (r0 || r1) begin
        op  = r1 ? int'(req1_op) : int'(req0_op);
        val = r1 ? int'(req1_value) : int'(req0_value);
        m_last = r1 ? 1 : 0;
        if (op == 3 || op == 7) e.rej = 1;
        else begin e.op = op; e.val = val; m_count++; end
        $display("load req%0d op=%0d value=%0d%s", r1 ? 1 : 0, op, val, e.rej ? " (rejected)" : "");
      end
    end else begin
      if (run_abort || m_cnt == 1) begin m_run = 0; m_cnt = 0; e.done = 1; end
      else m_cnt--;
    end
    if (m_run != 0) begin e.op = 0; e.val = 0; end
    e.mode = m_run; e.busy = m_run; e.count = m_count; e.full = (m_count == DEPTH) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (calc_mode) mode_cycles++;
    if (done) done_cnt++;
    if (reject) reject_cnt++;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("calc_mode",   32'(calc_mode),   got.mode);
      check("calc_opCode", 32'(calc_opCode), got.op);
      check("calc_value",  32'(calc_value),  got.val);
      check("load_count",  32'(load_count),  got.count);
      check("cache_full",  32'(cache_full),  got.full);
      check("busy",        32'(busy),        got.busy);
      check("done",        32'(done),        got.done);
      check("reject",      32'(reject),      got.rej);
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic load_n(int n);
    for (int i = 0; i < n; i++) begin
      drive_req(1, (i % 3) + 4, i + 3, 0, 0, 0);
      step();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    int guard;
    reset = 1'b0;
    clear_inputs();
    do_reset();

    // Single legal load from requester 0
    drive_req(1, 0, 5, 0, 0, 0); step();
    clear_inputs(); step(); step();

    // Tie for four cycles after a fresh reset: grants alternate 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_req(1, 1, i, 1, 2, 8 + i);
      step();
    end
    clear_inputs(); step();
    check("tie_count", 32'(load_count), 32'd4);

    // Illegal opcode from requester 1
    reject_cnt = 0;
    drive_req(0, 0, 0, 1, 3, 9); step();
    clear_inputs(); step(); step();
    check("reject_pulses", 32'(reject_cnt), 32'd1);
    check("reject_count", 32'(load_count), 32'd4);

    // Fill the cache, then confirm both requesters stall
    guard = 0;
    while (m_count < DEPTH && guard < 40) begin
      drive_req(1, guard % 3, guard % 16, 1, 4 + (guard % 3), 15 - (guard % 16));
      step();
      guard++;
    end
    check("fill_done", 32'(cache_full), 32'd1);
    drive_req(1, 0, 1, 1, 1, 2);
    repeat (4) step();
    check("stall_count", 32'(load_count), 32'(DEPTH));
    clear_inputs(); step();

    // Burst of 5 with 3 entries loaded
    do_reset();
    load_n(3);
    mode_cycles = 0; done_cnt = 0;
    run_start = 1'b1; run_cycles = 8'd5; step();
    clear_inputs();
    repeat (8) step();
    check("run_length", 32'(mode_cycles), 32'd5);
    check("run_done_pulses", 32'(done_cnt), 32'd1);

    // run_start with nothing loaded: done only
    do_reset();
    mode_cycles = 0; done_cnt = 0;
    run_start = 1'b1; run_cycles = 8'd4; step();
    clear_inputs(); step(); step();
    check("empty_run_mode", 32'(mode_cycles), 32'd0);
    check("empty_run_done", 32'(done_cnt), 32'd1);

    // Abort on the second RUN cycle
    load_n(2);
    mode_cycles = 0;
    run_start = 1'b1; run_cycles = 8'd10; step();
    clear_inputs(); step();
    run_abort = 1'b1; step();
    clear_inputs(); step(); step();
    check("abort_mode_cycles", 32'(mode_cycles), 32'd2);

    // Reset during RUN: reset values, no done
    load_n(1);
    done_cnt = 0;
    run_start = 1'b1; run_cycles = 8'd10; step();
    clear_inputs(); step(); step();
    reset = 1'b0; step();
    reset = 1'b1; step(); step();
    check("reset_run_done", 32'(done_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive_req($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 15),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 15));
      run_start  = ($urandom_range(0, 15) == 0);
      run_cycles = 8'($urandom_range(0, 6));
      run_abort  = ($urandom_range(0, 11) == 0);
      reset      = ($urandom_range(0, 79) != 0);
      step();
    end
    reset = 1'b1;
    clear_inputs(); step();

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
